// File: rtl/latch_writer.sv
// Timed write sequencer for a latch bank: setup / enable pulse / hold, then readback check.
// Optional readback compare and error counter are built when LATCH_WRITER_CHECK_EN is defined.
module latch_writer #(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic [WIDTH-1:0] d,
   output logic             enable,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] q_not,
   output logic             done,
   output logic             match,
   output logic [7:0]       err_count
);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

   // Counters hold "cycles remaining minus one" so a phase ends when they reach zero.
   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       match_r;
   logic       hold_end;
   logic       readback_ok;

   assign req_ready = (state == IDLE) && !reset;
   assign hold_end  = (state == HOLD) && (cnt == 4'd0);

`ifdef LATCH_WRITER_CHECK_EN
   logic [7:0] err_r;

   // d still carries the captured value, so it is the compare reference.
   assign readback_ok = (q == d) && (q_not == ~d);
   assign match       = match_r;
   assign err_count   = err_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 8'd0;
      end else if (hold_end && !readback_ok && (err_r != 8'hFF)) begin
         err_r <= err_r + 8'd1;
      end
   end
`else
   logic unused_readback;

   assign readback_ok     = 1'b0;
   assign unused_readback = ^{q, q_not, match_r};
   assign match           = 1'b0;
   assign err_count       = 8'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         d       <= '0;
         enable  <= 1'b0;
         done    <= 1'b0;
         match_r <= 1'b0;
      end else begin
         done    <= 1'b0;
         match_r <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  d     <= req_data;
                  cnt   <= SETUP_LD;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 4'd0) begin
                  cnt    <= PULSE_LD;
                  enable <= 1'b1;
                  state  <= PULSE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            PULSE: begin
               if (cnt == 4'd0) begin
                  cnt    <= HOLD_LD;
                  enable <= 1'b0;
                  state  <= HOLD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HOLD: begin
               if (cnt == 4'd0) begin
                  cnt     <= 4'd0;
                  done    <= 1'b1;
                  match_r <= readback_ok;
                  state   <= CHECK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            CHECK: begin
               cnt   <= 4'd0;
               state <= IDLE;
            end
            default: begin
               enable <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_writer.sv
// Bench for latch_writer with a behavioural latch model; expectations follow LATCH_WRITER_CHECK_EN.
module tb_latch_writer;

`ifdef LATCH_WRITER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_data;
   logic [7:0] d;
   logic       enable;
   logic [7:0] q;
   logic [7:0] q_not;
   logic       done;
   logic       match;
   logic [7:0] err_count;

   logic       force_zero;
   logic [7:0] lat;

   int n_chk  = 0;
   int n_fail = 0;

   latch_writer dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .d         (d),
      .enable    (enable),
      .q         (q),
      .q_not     (q_not),
      .done      (done),
      .match     (match),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Behavioural latch; force_zero models a bank whose true output is stuck low.
   always_latch begin
      if (enable) lat <= d;
   end
   assign q     = force_zero ? 8'h00 : lat;
   assign q_not = ~q;

   typedef struct {
      logic       v;
      logic [7:0] data;
      logic       fz;
      logic       ready;
      logic       en;
      logic       dn;
      logic       m;
      logic [7:0] dd;
   } vec_t;

   vec_t tv[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_row(input int i, input logic v, input logic [7:0] data, input logic fz,
                          input logic ready, input logic en, input logic dn, input logic m,
                          input logic [7:0] dd);
      tv[i].v = v;  tv[i].data = data; tv[i].fz = fz;
      tv[i].ready = ready; tv[i].en = en; tv[i].dn = dn; tv[i].m = m; tv[i].dd = dd;
   endtask

   // Starts at a negedge; returns at the negedge where done is seen (lat = cycles since acceptance).
   task automatic do_write(input logic [7:0] data, output int lat_o);
      lat_o = -1;
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      req_valid = 1'b1;
      req_data  = data;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (done) begin
            lat_o = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_v;
      int first_done;
      int second_done;
      int low_cnt;
      int done_cnt;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_data   = 8'h00;
      force_zero = 1'b0;

      // Write A5 then, back-to-back, FF against a stuck-low bank.
      set_row(0,  1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      set_row(1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
      set_row(2,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
      set_row(3,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
      set_row(4,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
      set_row(5,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, CHK,  8'hA5);
      set_row(6,  1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      set_row(7,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
      set_row(8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
      set_row(9,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
      set_row(10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
      set_row(11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
      set_row(12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_d", 32'(d), 32'h00);
      chk("rst_enable", 32'(enable), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tv[i].ready));
         chk($sformatf("row%0d_enable", i), 32'(enable), 32'(tv[i].en));
         chk($sformatf("row%0d_done", i), 32'(done), 32'(tv[i].dn));
         chk($sformatf("row%0d_match", i), 32'(match), 32'(tv[i].m));
         chk($sformatf("row%0d_d", i), 32'(d), 32'(tv[i].dd));
         if (i == 6) chk("err_after_good", 32'(err_count), 32'd0);
         req_valid  = tv[i].v;
         req_data   = tv[i].data;
         force_zero = tv[i].fz;
         @(negedge clk);
      end
      chk("err_after_bad", 32'(err_count), CHK ? 32'd1 : 32'd0);
      force_zero = 1'b0;

      // req_valid held high across two requests.
      first_done = -1; second_done = -1; low_cnt = 0;
      req_valid = 1'b1;
      req_data  = 8'h3C;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("b2b_d_first", 32'(d), 32'h3C);
            req_data = 8'hC3;
         end
         if (c <= 5 && !req_ready) low_cnt++;
         if (c == 6) chk("b2b_ready_idle", 32'(req_ready), 32'd1);
         if (c == 7) begin
            chk("b2b_d_second", 32'(d), 32'hC3);
            req_valid = 1'b0;
         end
         if (done) begin
            if (first_done < 0) first_done = c;
            else second_done = c;
         end
      end
      chk("b2b_ready_low_cycles", 32'(low_cnt), 32'd5);
      chk("b2b_first_done", 32'(first_done), 32'd5);
      chk("b2b_done_spacing", 32'(second_done - first_done), 32'd6);

      // Reset during the enable pulse aborts the write.
      req_valid = 1'b1;
      req_data  = 8'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_enable_before", 32'(enable), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_enable", 32'(enable), 32'd0);
      chk("abort_d", 32'(d), 32'h00);
      chk("abort_ready_in_reset", 32'(req_ready), 32'd0);
      chk("abort_err", 32'(err_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", 32'(req_ready), 32'd1);
      done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);

      // Error counter saturation.
      force_zero = 1'b1;
      for (int w = 1; w <= 300; w++) begin
         do_write(8'hFF, lat_v);
         if (w == 1 || w == 300) begin
            chk($sformatf("sat_lat_w%0d", w), 32'(lat_v), 32'd5);
            chk($sformatf("sat_match_w%0d", w), 32'(match), 32'd0);
         end
         if (w == 254) chk("sat_err_254", 32'(err_count), CHK ? 32'd254 : 32'd0);
         if (w == 255) chk("sat_err_255", 32'(err_count), CHK ? 32'd255 : 32'd0);
      end
      @(negedge clk);
      chk("sat_err_300", 32'(err_count), CHK ? 32'd255 : 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
